// File: rtl/dmem_lat.sv
// dmem_lat: multi-cycle data memory with request/ready handshake, byte-lane stores and error reporting.
// Define DMEM_ALIGN_CHECK_EN to reject accesses whose a[1:0] is not zero.
module dmem_lat #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [31:0]        a,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd,
  output logic               ready,
  output logic               err
);
  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [NB-1:0]    wr_be;
  logic [WIDTH-1:0] wr_data;
  function automatic logic bad(input logic [31:0] x);
`ifdef DMEM_ALIGN_CHECK_EN
    return x >= 32'(DEPTH * 4) || x[1:0] != 2'b00;
`else
    return x >= 32'(DEPTH * 4);
`endif
  endfunction
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  generate
    if (LATENCY == 0) begin : g_comb
      assign ready   = req;
      assign err     = req & bad(a);
      assign rd      = (req && !bad(a)) ? mem[a[AW+1:2]] : '0;
      assign wr_en   = reset & req & we & ~bad(a);
      assign wr_idx  = a[AW+1:2];
      assign wr_be   = be;
      assign wr_data = wd;
    end else begin : g_fsm
      typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
      state_t           state, nxt;
      logic [3:0]       cnt;
      logic             we_q;
      logic [NB-1:0]    be_q;
      logic [31:0]      a_q, src;
      logic [WIDTH-1:0] wd_q;
      // With LATENCY=1 RESP is entered on the acceptance edge, before a_q is loaded.
      assign src = (state == IDLE) ? a : a_q;
      always_comb begin
        nxt = IDLE;
        if (state == IDLE) nxt = req ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
        else if (state == WAIT) nxt = (cnt == 4'd1) ? RESP : WAIT;
      end
      always_ff @(posedge clk)
        if (!reset) begin
          state <= IDLE;
          cnt   <= '0;
          rd    <= '0;
          err   <= 1'b0;
        end else begin
          state <= nxt;
          if (state == IDLE && req) begin
            we_q <= we;
            be_q <= be;
            a_q  <= a;
            wd_q <= wd;
            cnt  <= 4'(LATENCY - 1);
          end else if (state == WAIT) cnt <= cnt - 4'd1;
          if (nxt == RESP && state != RESP) begin
            rd  <= bad(src) ? '0 : mem[src[AW+1:2]];
            err <= bad(src);
          end
        end
      assign ready   = (state == RESP);
      assign wr_en   = reset & ready & we_q & ~err;
      assign wr_idx  = a_q[AW+1:2];
      assign wr_be   = be_q;
      assign wr_data = wd_q;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_lat.sv
// tb_dmem_lat: directed checks of dmem_lat at LATENCY 2, 3, 4 and 0.
module tb_dmem_lat;
  logic        clk = 1'b0;
  logic        rst_n, r4n;
  logic [2:0]  rq;
  logic        req0, we;
  logic [3:0]  be;
  logic [31:0] a, wd, rd0;
  logic        ready0, err0;
  logic [31:0] rdv [3];
  logic        rdy [3];
  logic        erv [3];
  int n_cmp = 0, n_err = 0;
  int lat;
  logic [31:0] r;
  logic e;
  logic [11:0] pulses;
  logic any;
  always #5 clk = ~clk;
  dmem_lat #(.LATENCY(2)) u2 (.clk(clk), .reset(rst_n), .req(rq[0]), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rdv[0]), .ready(rdy[0]), .err(erv[0]));
  dmem_lat #(.LATENCY(3)) u3 (.clk(clk), .reset(rst_n), .req(rq[1]), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rdv[1]), .ready(rdy[1]), .err(erv[1]));
  dmem_lat #(.LATENCY(4)) u4 (.clk(clk), .reset(rst_n & r4n), .req(rq[2]), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rdv[2]), .ready(rdy[2]), .err(erv[2]));
  dmem_lat #(.LATENCY(0)) u0 (.clk(clk), .reset(rst_n), .req(req0), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rd0), .ready(ready0), .err(err0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic acc(input int s, input logic w, input logic [3:0] b, input logic [31:0] ad,
                     input logic [31:0] d, output int l, output logic [31:0] rr, output logic ee);
    @(negedge clk);
    rq[s] = 1'b1; we = w; be = b; a = ad; wd = d;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!rdy[s] && l < 20);
    rr = rdv[s];
    ee = erv[s];
    rq[s] = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; r4n = 1'b1; rq = '0; req0 = 1'b0;
    we = 1'b0; be = '0; a = '0; wd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_err", 32'(erv[0]), 32'd0);
    chk("rst_rd", rdv[0], 32'd0);
    rst_n = 1'b1;
    acc(0, 1'b1, 4'hF, 32'd252, 32'd210, lat, r, e);
    chk("st252_lat", 32'(lat), 32'd2);
    chk("st252_err", 32'(e), 32'd0);
    acc(0, 1'b0, 4'hF, 32'd252, 32'd0, lat, r, e);
    chk("ld252_lat", 32'(lat), 32'd2);
    chk("ld252_rd", r, 32'd210);
    acc(0, 1'b1, 4'hF, 32'd8, 32'hAABBCCDD, lat, r, e);
    acc(0, 1'b1, 4'b0001, 32'd8, 32'h00000011, lat, r, e);
    chk("st8_lane_prev", r, 32'hAABBCCDD);
    acc(0, 1'b0, 4'hF, 32'd8, 32'd0, lat, r, e);
    chk("ld8_lane", r, 32'hAABBCC11);
    acc(0, 1'b1, 4'h0, 32'd8, 32'hFFFFFFFF, lat, r, e);
    chk("be0_err", 32'(e), 32'd0);
    chk("be0_lat", 32'(lat), 32'd2);
    acc(0, 1'b0, 4'hF, 32'd8, 32'd0, lat, r, e);
    chk("be0_unchanged", r, 32'hAABBCC11);
    acc(0, 1'b1, 4'hF, 32'd256, 32'hDEADBEEF, lat, r, e);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rd", r, 32'd0);
    acc(0, 1'b0, 4'hF, 32'd252, 32'd0, lat, r, e);
    chk("oor_word63", r, 32'd210);
    @(negedge clk);
    rq[1] = 1'b1; we = 1'b0; a = 32'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pulses[k] = rdy[1];
    end
    rq[1] = 1'b0;
    chk("l3_pulses", 32'(pulses), 32'h444);
    acc(2, 1'b1, 4'hF, 32'd4, 32'd77, lat, r, e);
    chk("l4_lat", 32'(lat), 32'd4);
    @(negedge clk);
    rq[2] = 1'b1; we = 1'b1; be = 4'hF; a = 32'd4; wd = 32'd5;
    @(negedge clk);
    @(negedge clk);
    r4n = 1'b0; rq[2] = 1'b0;
    @(negedge clk);
    chk("l4_rst_ready", 32'(rdy[2]), 32'd0);
    r4n = 1'b1;
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any = any | rdy[2];
    end
    chk("l4_no_late_ready", 32'(any), 32'd0);
    acc(2, 1'b0, 4'hF, 32'd4, 32'd0, lat, r, e);
    chk("l4_old_value", r, 32'd77);
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; be = 4'hF; a = 32'd252; wd = 32'd210;
    #1 chk("l0_st_ready", 32'(ready0), 32'd1);
    chk("l0_st_err", 32'(err0), 32'd0);
    @(negedge clk);
    we = 1'b0;
    #1 chk("l0_ld_ready", 32'(ready0), 32'd1);
    chk("l0_ld_rd", rd0, 32'd210);
    req0 = 1'b0;
    #1 chk("l0_idle_ready", 32'(ready0), 32'd0);
    acc(0, 1'b1, 4'hF, 32'd4, 32'h12345678, lat, r, e);
    acc(0, 1'b0, 4'hF, 32'd6, 32'd0, lat, r, e);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis6_err", 32'(e), 32'd1);
    chk("mis6_rd", r, 32'd0);
`else
    chk("mis6_err", 32'(e), 32'd0);
    chk("mis6_rd", r, 32'h12345678);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
